dp_ram_ctrl: RTL and testbench

- Parametrised successor to the single-clock instruction/data RAM.
- Simple dual-port synchronous RAM: one write port, one read port.
- Adds byte-lane write enables, selectable read latency with a read-valid strobe, and same-address write-to-read forwarding.
- Adds a post-reset hardware clear sequencer with a busy flag. Sits between the CPU fetch/load-store units and on-chip block RAM.

---
 rtl/dp_ram_ctrl.sv | 174 +++++++++++++++++
 tb/tb_dp_ram_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dp_ram_ctrl.sv
// Simple dual-port RAM controller: byte-lane writes, 1/2-cycle read latency, same-address forwarding, post-reset clear.
// Optional per-lane even parity with error injection when DP_RAM_PARITY_EN is defined.
module dp_ram_ctrl #(
    parameter int    ADDR_WIDTH     = 10,
    parameter int    DATA_WIDTH     = 16,
    parameter int    RD_LATENCY     = 1,
    parameter int    CLEAR_ON_RESET = 1,
    parameter string INIT_FILE      = ""
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      w_en,
    input  logic [ADDR_WIDTH-1:0]     w_addr,
    input  logic [DATA_WIDTH/8-1:0]   w_be,
    input  logic [DATA_WIDTH-1:0]     din,
    input  logic                      r_en,
    input  logic [ADDR_WIDTH-1:0]     r_addr,
    output logic [DATA_WIDTH-1:0]     dout,
    output logic                      r_valid,
`ifdef DP_RAM_PARITY_EN
    input  logic                      err_inject,
    output logic                      parity_err,
`endif
    output logic                      busy
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LANES = DATA_WIDTH / 8;
    localparam bit CLEAR_EN = (CLEAR_ON_RESET != 0) && (INIT_FILE == "");
    localparam logic [ADDR_WIDTH-1:0] CNT_MAX = '1;

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("dp_ram_ctrl: RD_LATENCY must be 1 or 2");
    end
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
        $error("dp_ram_ctrl: DATA_WIDTH must be a non-zero multiple of 8");
    end

    typedef enum logic {CLEAR, READY} state_t;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   cnt_reg;
    logic                    busy_reg;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    wr_ok;
    logic                    rd_ok;
    logic                    fwd_hit;
    logic [ADDR_WIDTH-1:0]   wr_addr_next;
    logic [DATA_WIDTH-1:0]   wr_data_next;
    logic [LANES-1:0]        wr_lane_next;
    logic [DATA_WIDTH-1:0]   rd_word_next;
    logic [DATA_WIDTH-1:0]   s1_data_reg;
    logic                    s1_valid_reg;

    assign wr_ok   = (state_reg == READY) && w_en;
    assign rd_ok   = (state_reg == READY) && r_en;
    assign fwd_hit = wr_ok && (w_addr == r_addr);
    assign busy    = busy_reg;

    // The clear sequencer owns the write port while it runs.
    always_comb begin
        wr_addr_next = w_addr;
        wr_data_next = din;
        wr_lane_next = wr_ok ? w_be : '0;
        if (state_reg == CLEAR) begin
            wr_addr_next = cnt_reg;
            wr_data_next = '0;
            wr_lane_next = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (CLEAR_EN) state_reg <= CLEAR;
            else          state_reg <= READY;
            cnt_reg  <= '0;
            busy_reg <= CLEAR_EN;
        end else begin
            case (state_reg)
                CLEAR: begin
                    if (cnt_reg == CNT_MAX) begin
                        state_reg <= READY;
                        busy_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DP_RAM_PARITY_EN
    logic [LANES-1:0]        par_mem [DEPTH];
    logic [LANES-1:0]        inj_lane;
    logic [LANES-1:0]        wr_par_next;
    logic [LANES-1:0]        lane_err_next;
    logic                    s1_err_reg;

    assign inj_lane = LANES'(err_inject);
`endif

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (wr_lane_next[i]) begin
                mem[wr_addr_next][8*i +: 8] <= wr_data_next[8*i +: 8];
`ifdef DP_RAM_PARITY_EN
                par_mem[wr_addr_next][i] <= wr_par_next[i];
`endif
            end
        end
    end

    // Forwarding is decided per lane: enabled lanes of a colliding write bypass the array.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign rd_word_next[8*gi +: 8] = (fwd_hit && w_be[gi]) ? din[8*gi +: 8]
                                                               : mem[r_addr][8*gi +: 8];
`ifdef DP_RAM_PARITY_EN
        assign wr_par_next[gi]   = (^wr_data_next[8*gi +: 8]) ^ (inj_lane[gi] & wr_ok);
        assign lane_err_next[gi] = (fwd_hit && w_be[gi]) ? inj_lane[gi]
                                 : ((^mem[r_addr][8*gi +: 8]) != par_mem[r_addr][gi]);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data_reg  <= '0;
            s1_valid_reg <= 1'b0;
`ifdef DP_RAM_PARITY_EN
            s1_err_reg   <= 1'b0;
`endif
        end else begin
            s1_valid_reg <= rd_ok;
            if (rd_ok) s1_data_reg <= rd_word_next;
`ifdef DP_RAM_PARITY_EN
            s1_err_reg   <= rd_ok && (|lane_err_next);
`endif
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] s2_data_reg;
        logic                  s2_valid_reg;
`ifdef DP_RAM_PARITY_EN
        logic                  s2_err_reg;
`endif
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_data_reg  <= '0;
                s2_valid_reg <= 1'b0;
`ifdef DP_RAM_PARITY_EN
                s2_err_reg   <= 1'b0;
`endif
            end else begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) s2_data_reg <= s1_data_reg;
`ifdef DP_RAM_PARITY_EN
                s2_err_reg   <= s1_err_reg;
`endif
            end
        end
        assign dout    = s2_data_reg;
        assign r_valid = s2_valid_reg;
`ifdef DP_RAM_PARITY_EN
        assign parity_err = s2_err_reg;
`endif
    end else begin : g_lat1
        assign dout    = s1_data_reg;
        assign r_valid = s1_valid_reg;
`ifdef DP_RAM_PARITY_EN
        assign parity_err = s1_err_reg;
`endif
    end
endmodule

// File: tb/tb_dp_ram_ctrl.sv
// Bench for dp_ram_ctrl: latency-1 and latency-2 instances share stimulus and are checked against a word-level model.
// Parity checks are compiled in when DP_RAM_PARITY_EN is defined.
module tb_dp_ram_ctrl;
    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          w_en = 1'b0;
    logic [AW-1:0] w_addr = '0;
    logic [1:0]    w_be = '0;
    logic [DW-1:0] din = '0;
    logic          r_en = 1'b0;
    logic [AW-1:0] r_addr = '0;
    logic [DW-1:0] dout1, dout2;
    logic          rv1, rv2, busy1, busy2;
`ifdef DP_RAM_PARITY_EN
    logic          err_inj = 1'b0;
    logic          pe1, pe2;
`endif

    always #5 clk = ~clk;

    dp_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .CLEAR_ON_RESET(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_addr(w_addr), .w_be(w_be), .din(din),
        .r_en(r_en), .r_addr(r_addr), .dout(dout1), .r_valid(rv1),
`ifdef DP_RAM_PARITY_EN
        .err_inject(err_inj), .parity_err(pe1),
`endif
        .busy(busy1)
    );

    dp_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .CLEAR_ON_RESET(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_addr(w_addr), .w_be(w_be), .din(din),
        .r_en(r_en), .r_addr(r_addr), .dout(dout2), .r_valid(rv2),
`ifdef DP_RAM_PARITY_EN
        .err_inject(err_inj), .parity_err(pe2),
`endif
        .busy(busy2)
    );

    typedef struct {
        int          due;
        logic [15:0] data;
        logic        err;
    } rd_t;

    logic [15:0] mem_m [16];
    logic        perr_m [16];
    rd_t         q1[$];
    rd_t         q2[$];
    logic [15:0] last1, last2;
    int          clear_left;
    int          cyc;
    int          total;
    int          bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        w_en = 1'b0; r_en = 1'b0; w_be = '0;
        rst_n = 1'b0;
        q1.delete(); q2.delete();
        last1 = '0; last2 = '0;
        #1;
        check("rst_dout1", 32'(dout1), 32'h0);
        check("rst_rvalid1", 32'(rv1), 32'h0);
        check("rst_busy1", 32'(busy1), 32'h1);
        check("rst_dout2", 32'(dout2), 32'h0);
        check("rst_rvalid2", 32'(rv2), 32'h0);
        check("rst_busy2", 32'(busy2), 32'h1);
`ifdef DP_RAM_PARITY_EN
        check("rst_perr1", 32'(pe1), 32'h0);
        check("rst_perr2", 32'(pe2), 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        clear_left = 16;
        for (int a = 0; a < 16; a++) begin
            mem_m[a]  = '0;
            perr_m[a] = 1'b0;
        end
    endtask

    // One clock: drive at negedge, update the model, check both instances 1ns after the rising edge.
    task automatic step(input logic we, input logic [3:0] wa, input logic [1:0] be, input logic [15:0] wd,
                        input logic re, input logic [3:0] ra, input logic inj);
        rd_t         e;
        logic [15:0] rd;
        logic        rerr;
        logic        ev1, ev2, ee1, ee2;
        w_en = we; w_addr = wa; w_be = be; din = wd; r_en = re; r_addr = ra;
`ifdef DP_RAM_PARITY_EN
        err_inj = inj;
`endif
        if (clear_left == 0) begin
            if (re) begin
                rd   = mem_m[ra];
                rerr = perr_m[ra];
                if (we && wa == ra) begin
                    if (be[0]) begin rd[7:0] = wd[7:0]; rerr = inj; end
                    if (be[1]) rd[15:8] = wd[15:8];
                end
                e.data = rd; e.err = rerr;
                e.due = cyc + 1; q1.push_back(e);
                e.due = cyc + 2; q2.push_back(e);
            end
            if (we) begin
                if (be[0]) begin mem_m[wa][7:0] = wd[7:0]; perr_m[wa] = inj; end
                if (be[1]) mem_m[wa][15:8] = wd[15:8];
            end
        end
        @(posedge clk);
        cyc++;
        if (clear_left > 0) clear_left--;
        #1;
        ev1 = (q1.size() > 0) && (q1[0].due == cyc);
        ee1 = 1'b0;
        if (ev1) begin last1 = q1[0].data; ee1 = q1[0].err; void'(q1.pop_front()); end
        ev2 = (q2.size() > 0) && (q2[0].due == cyc);
        ee2 = 1'b0;
        if (ev2) begin last2 = q2[0].data; ee2 = q2[0].err; void'(q2.pop_front()); end
        check("rvalid_lat1", 32'(rv1), 32'(ev1));
        check("dout_lat1", 32'(dout1), 32'(last1));
        check("busy_lat1", 32'(busy1), 32'(clear_left > 0));
        check("rvalid_lat2", 32'(rv2), 32'(ev2));
        check("dout_lat2", 32'(dout2), 32'(last2));
        check("busy_lat2", 32'(busy2), 32'(clear_left > 0));
`ifdef DP_RAM_PARITY_EN
        check("perr_lat1", 32'(pe1), 32'(ev1 & ee1));
        check("perr_lat2", 32'(pe2), 32'(ev2 & ee2));
`else
        if (ee1 || ee2) cyc = cyc + 0;
`endif
        $display("cyc=%0d we=%0b wa=%0h be=%b din=%h re=%0b ra=%0h | busy=%0b rv1=%0b d1=%h rv2=%0b d2=%h",
                 cyc, we, wa, be, wd, re, ra, busy1, rv1, dout1, rv2, dout2);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 2'b00, 16'h0, 1'b0, 4'h0, 1'b0);
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; clear_left = 0;
        last1 = '0; last2 = '0;

        // Clear with requests present, aborted at count 7, then a full restart.
        apply_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 4'(i), 2'b11, 16'hBEEF, 1'b1, 4'(i), 1'b0);
        apply_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 2'b11, 16'hDEAD, 1'b1, 4'(i), 1'b0);

        // Every address reads back zero, back-to-back.
        for (int a = 0; a < 16; a++) step(1'b0, 4'h0, 2'b00, 16'h0, 1'b1, 4'(a), 1'b0);
        idle(2);

        // Byte enables.
        step(1'b1, 4'h3, 2'b11, 16'hABCD, 1'b0, 4'h0, 1'b0);
        step(1'b1, 4'h3, 2'b10, 16'h1200, 1'b0, 4'h0, 1'b0);
        step(1'b1, 4'h3, 2'b00, 16'hFFFF, 1'b1, 4'h3, 1'b0);
        idle(2);

        // Forwarding of the enabled lane only.
        step(1'b1, 4'h5, 2'b11, 16'h1111, 1'b0, 4'h0, 1'b0);
        step(1'b1, 4'h5, 2'b01, 16'h2222, 1'b1, 4'h5, 1'b0);
        idle(2);

        // Throughput: three consecutive reads.
        step(1'b1, 4'h0, 2'b11, 16'hA0A0, 1'b0, 4'h0, 1'b0);
        step(1'b1, 4'h1, 2'b11, 16'hB1B1, 1'b0, 4'h0, 1'b0);
        step(1'b1, 4'h2, 2'b11, 16'hC2C2, 1'b0, 4'h0, 1'b0);
        step(1'b0, 4'h0, 2'b00, 16'h0, 1'b1, 4'h0, 1'b0);
        step(1'b0, 4'h0, 2'b00, 16'h0, 1'b1, 4'h1, 1'b0);
        step(1'b0, 4'h0, 2'b00, 16'h0, 1'b1, 4'h2, 1'b0);
        idle(3);

        // Parity injection and repair.
        step(1'b1, 4'h2, 2'b11, 16'h00FF, 1'b0, 4'h0, 1'b1);
        step(1'b0, 4'h0, 2'b00, 16'h0, 1'b1, 4'h2, 1'b0);
        idle(2);
        step(1'b1, 4'h2, 2'b11, 16'h00FF, 1'b0, 4'h0, 1'b0);
        step(1'b0, 4'h0, 2'b00, 16'h0, 1'b1, 4'h2, 1'b0);
        idle(2);

        // Random traffic with frequent address collisions.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] wa, ra;
            wa = 4'($urandom_range(0, 7));
            ra = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 7));
            step(1'($urandom_range(0, 1)), wa, 2'($urandom_range(0, 3)), 16'($urandom),
                 1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 3) == 0));
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
